// File: rtl/step_pulse_gen.sv
// -----------------------------------------------------------------------------
// step_pulse_gen
//   Multi-channel stepper pulse generator. Each channel runs its own
//   IDLE/SETUP/HIGH/LOW/COOL machine. It emits a programmed number of step
//   pulses with a period of 2*hp clocks. A direction setup delay comes before
//   the first pulse and a cooldown window follows each move. A move can be
//   aborted, and the channel then reports the steps it did not issue.
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-low reset
//   start        per-channel start strobe (accepted only while idle)
//   abort        per-channel abort strobe (acts in SETUP/HIGH/LOW)
//   dir_in       per-channel direction, latched at an accepted start
//   half_period  per-channel half-period in clocks, ch i at [i*DIV_W +: DIV_W]
//   step_count   per-channel steps to emit, ch i at [i*CNT_W +: CNT_W]
//   step_out     step pulses to the driver
//   dir_out      direction to the driver, holds the last latched value
//   busy         channel is in SETUP/HIGH/LOW/COOL
//   done         1-cycle strobe on completion or abort
//   remaining    per-channel steps not yet completed
// -----------------------------------------------------------------------------
module step_pulse_gen #(
  parameter int CHANNELS  = 4,
  parameter int DIV_W     = 32,
  parameter int CNT_W     = 31,
  parameter int DIR_SETUP = 8,
  parameter int COOLDOWN  = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       start,
  input  logic [CHANNELS-1:0]       abort,
  input  logic [CHANNELS-1:0]       dir_in,
  input  logic [CHANNELS*DIV_W-1:0] half_period,
  input  logic [CHANNELS*CNT_W-1:0] step_count,
  output logic [CHANNELS-1:0]       step_out,
  output logic [CHANNELS-1:0]       dir_out,
  output logic [CHANNELS-1:0]       busy,
  output logic [CHANNELS-1:0]       done,
  output logic [CHANNELS*CNT_W-1:0] remaining
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_COOL  = 3'd4
  } state_t;

  localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // SETUP is entered on the accept edge and counts DIR_SETUP down to 0. The
  // first rise therefore lands DIR_SETUP+1 edges after the accept edge. With
  // DIR_SETUP==0 this is the single edge needed to register step_out.
  localparam logic [DIV_W-1:0] SETUP_LOAD = DIV_W'(DIR_SETUP);
  localparam logic [DIV_W-1:0] COOL_LOAD  = (COOLDOWN > 0) ? DIV_W'(COOLDOWN - 1) : DIV_ZERO;

  // A move that ends (normally or by abort) goes through COOL unless no
  // cooldown is configured, in which case it drops straight to IDLE.
  localparam state_t END_STATE = (COOLDOWN == 0) ? ST_IDLE : ST_COOL;
  localparam logic   END_BUSY  = (COOLDOWN == 0) ? 1'b0 : 1'b1;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    state_t           r_state;
    logic [DIV_W-1:0] r_hp;
    logic [DIV_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_rem;
    logic             r_step;
    logic             r_dir;
    logic             r_busy;
    logic             r_done;
    logic [DIV_W-1:0] w_hp_in;
    logic [CNT_W-1:0] w_cnt_in;
    logic             w_cnt_zero;

    assign w_hp_in    = half_period[g*DIV_W +: DIV_W];
    assign w_cnt_in   = step_count[g*CNT_W +: CNT_W];
    assign w_cnt_zero = (r_cnt == DIV_ZERO);

    // Per-channel move FSM with all outputs registered alongside the state.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_state <= ST_IDLE;
        r_hp    <= DIV_ONE;
        r_cnt   <= DIV_ZERO;
        r_rem   <= CNT_ZERO;
        r_step  <= 1'b0;
        r_dir   <= 1'b0;
        r_busy  <= 1'b0;
        r_done  <= 1'b0;
      end else begin
        r_done <= 1'b0;
        case (r_state)
          ST_IDLE: begin
            if (start[g] && !abort[g]) begin
              r_hp  <= (w_hp_in == DIV_ZERO) ? DIV_ONE : w_hp_in;
              r_rem <= w_cnt_in;
              r_dir <= dir_in[g];
              if (w_cnt_in == CNT_ZERO) begin
                r_done <= 1'b1;
              end else begin
                r_state <= ST_SETUP;
                r_cnt   <= SETUP_LOAD;
                r_busy  <= 1'b1;
              end
            end
          end
          ST_SETUP: begin
            if (abort[g]) begin
              r_state <= END_STATE;
              r_busy  <= END_BUSY;
              r_cnt   <= COOL_LOAD;
              r_done  <= 1'b1;
            end else if (w_cnt_zero) begin
              r_state <= ST_HIGH;
              r_step  <= 1'b1;
              r_cnt   <= r_hp - DIV_ONE;
            end else begin
              r_cnt <= r_cnt - DIV_ONE;
            end
          end
          ST_HIGH: begin
            // A pulse cut short by abort still counts as issued.
            if (abort[g]) begin
              r_state <= END_STATE;
              r_busy  <= END_BUSY;
              r_cnt   <= COOL_LOAD;
              r_step  <= 1'b0;
              r_rem   <= r_rem - CNT_ONE;
              r_done  <= 1'b1;
            end else if (w_cnt_zero) begin
              r_state <= ST_LOW;
              r_step  <= 1'b0;
              r_cnt   <= r_hp - DIV_ONE;
              r_rem   <= r_rem - CNT_ONE;
            end else begin
              r_cnt <= r_cnt - DIV_ONE;
            end
          end
          ST_LOW: begin
            if (abort[g] || (w_cnt_zero && (r_rem == CNT_ZERO))) begin
              r_state <= END_STATE;
              r_busy  <= END_BUSY;
              r_cnt   <= COOL_LOAD;
              r_done  <= 1'b1;
            end else if (w_cnt_zero) begin
              r_state <= ST_HIGH;
              r_step  <= 1'b1;
              r_cnt   <= r_hp - DIV_ONE;
            end else begin
              r_cnt <= r_cnt - DIV_ONE;
            end
          end
          ST_COOL: begin
            if (w_cnt_zero) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_cnt <= r_cnt - DIV_ONE;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_step  <= 1'b0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end

    assign step_out[g]                 = r_step;
    assign dir_out[g]                  = r_dir;
    assign busy[g]                     = r_busy;
    assign done[g]                     = r_done;
    assign remaining[g*CNT_W +: CNT_W] = r_rem;
  end

endmodule

// File: tb/tb_step_pulse_gen.sv
// -----------------------------------------------------------------------------
// tb_step_pulse_gen
//   Self-checking bench for step_pulse_gen. The reference model describes
//   each move by its accept edge, step count, half-period and end edge. Every
//   output is derived from those numbers by arithmetic on the edge index.
// -----------------------------------------------------------------------------
module tb_step_pulse_gen;
  localparam int CH    = 4;
  localparam int DIV_W = 32;
  localparam int CNT_W = 31;
  localparam int DS    = 8;
  localparam int CD    = 5;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [CH-1:0]          start, abort, dir_in;
  logic [CH*DIV_W-1:0]    half_period;
  logic [CH*CNT_W-1:0]    step_count;
  logic [CH-1:0]          step_out, dir_out, busy, done;
  logic [CH*CNT_W-1:0]    remaining;

  step_pulse_gen #(.CHANNELS(CH), .DIV_W(DIV_W), .CNT_W(CNT_W), .DIR_SETUP(DS), .COOLDOWN(CD)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .dir_in(dir_in),
    .half_period(half_period), .step_count(step_count), .step_out(step_out),
    .dir_out(dir_out), .busy(busy), .done(done), .remaining(remaining)
  );

  always #5 clk = ~clk;

  int     n_cmp = 0;
  int     n_err = 0;
  longint cyc   = 0;

  // Reference model: one record per channel describing its latest move.
  bit     m_valid [CH];
  bit     m_dir   [CH];
  longint m_s0    [CH];
  longint m_te    [CH];
  longint m_hp    [CH];
  longint m_n     [CH];

  function automatic bit f_high(int c, longint t);
    longint x;
    if (!m_valid[c] || m_n[c] == 0 || t >= m_te[c]) return 1'b0;
    x = t - (m_s0[c] + DS + 1);
    if (x < 0) return 1'b0;
    return (x % (2 * m_hp[c])) < m_hp[c];
  endfunction

  function automatic longint f_completed(int c, longint t);
    longint x, k;
    if (!m_valid[c]) return 0;
    x = t - (m_s0[c] + DS + 1 + m_hp[c]);
    if (x < 0) return 0;
    k = x / (2 * m_hp[c]) + 1;
    return (k > m_n[c]) ? m_n[c] : k;
  endfunction

  function automatic longint f_rem(int c, longint t);
    if (!m_valid[c]) return 0;
    if (t >= m_te[c])
      return m_n[c] - f_completed(c, m_te[c] - 1) - longint'(f_high(c, m_te[c] - 1));
    return m_n[c] - f_completed(c, t);
  endfunction

  function automatic bit f_busy(int c, longint t);
    return m_valid[c] && (m_n[c] > 0) && (t >= m_s0[c]) && (t < m_te[c] + CD);
  endfunction

  function automatic bit f_done(int c, longint t);
    return m_valid[c] && (t == m_te[c]);
  endfunction

  function automatic logic [CNT_W+3:0] exp_vec(int c, longint t);
    return {f_high(c, t), m_dir[c], f_busy(c, t), f_done(c, t), CNT_W'(f_rem(c, t))};
  endfunction

  function automatic void model_edge(int c, longint t, bit st, bit ab, bit d,
                                     longint hpv, longint cnv);
    if (!f_busy(c, t - 1)) begin
      if (st && !ab) begin
        m_valid[c] = 1'b1;
        m_s0[c]    = t;
        m_n[c]     = cnv;
        m_hp[c]    = (hpv == 0) ? 1 : hpv;
        m_dir[c]   = d;
        m_te[c]    = (cnv == 0) ? t : t + DS + 1 + 2 * m_hp[c] * cnv;
      end
    end else if (ab && t > m_s0[c] && t <= m_te[c]) begin
      m_te[c] = t;
    end
  endfunction

  function automatic void model_clear();
    for (int c = 0; c < CH; c++) begin
      m_valid[c] = 1'b0;
      m_dir[c]   = 1'b0;
    end
  endfunction

  task automatic set_ch(int c, int hp, int cnt, bit d);
    half_period[c*DIV_W +: DIV_W] = DIV_W'(hp);
    step_count[c*CNT_W +: CNT_W]  = CNT_W'(cnt);
    dir_in[c]                     = d;
  endtask

  // Advance one clock edge: update the model from the applied inputs, then
  // let the DUT take the edge and release the strobes 1 time unit later.
  task automatic tick();
    longint t;
    t = cyc + 1;
    if (reset) begin
      for (int c = 0; c < CH; c++)
        model_edge(c, t, start[c], abort[c], dir_in[c],
                   longint'(half_period[c*DIV_W +: DIV_W]),
                   longint'(step_count[c*CNT_W +: CNT_W]));
    end
    @(posedge clk);
    cyc = t;
    #1;
    start = '0;
    abort = '0;
  endtask

  task automatic test_reset();
    logic [CNT_W+3:0] e, g;
    reset = 1'b1;
    #2 reset = 1'b0;
    model_clear();
    #1;
    for (int c = 0; c < CH; c++) begin
      e = exp_vec(c, cyc);
      g = {step_out[c], dir_out[c], busy[c], done[c], remaining[c*CNT_W +: CNT_W]};
      n_cmp++;
      if (g !== e) begin n_err++; $display("FAIL reset ch%0d: got %h expected %h", c, g, e); end
    end
    tick(); tick();
    reset = 1'b1;
  endtask

  task automatic test_basic(string name);
    logic [CNT_W+3:0] e, g;
    longint s0, rise;
    rise = -1;
    set_ch(0, 1, 3, 1'b1);
    start[0] = 1'b1;
    tick();
    s0 = cyc;
    for (int i = 0; i < 25; i++) begin
      if (i > 0) tick();
      if (step_out[0] && rise < 0) rise = cyc - s0;
      for (int c = 0; c < CH; c++) begin
        e = exp_vec(c, cyc);
        g = {step_out[c], dir_out[c], busy[c], done[c], remaining[c*CNT_W +: CNT_W]};
        n_cmp++;
        if (g !== e) begin n_err++; $display("FAIL %s ch%0d edge %0d: got %h expected %h", name, c, cyc, g, e); end
      end
    end
    n_cmp++;
    if (rise !== 64'(DS + 1)) begin n_err++; $display("FAIL %s_first_rise: got %0d expected %0d", name, rise, DS + 1); end
  endtask

  task automatic test_hp_zero();
    logic [CNT_W+3:0] e, g;
    set_ch(1, 0, 2, 1'b0);
    start[1] = 1'b1;
    for (int i = 0; i < 22; i++) begin
      tick();
      for (int c = 0; c < CH; c++) begin
        e = exp_vec(c, cyc);
        g = {step_out[c], dir_out[c], busy[c], done[c], remaining[c*CNT_W +: CNT_W]};
        n_cmp++;
        if (g !== e) begin n_err++; $display("FAIL hp_zero ch%0d edge %0d: got %h expected %h", c, cyc, g, e); end
      end
    end
    set_ch(1, 3, 0, 1'b1);
    start[1] = 1'b1;
    tick();
    n_cmp++;
    if ({done[1], busy[1], step_out[1]} !== 3'b100) begin
      n_err++; $display("FAIL count_zero done/busy/step: got %b expected 100", {done[1], busy[1], step_out[1]});
    end
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      for (int c = 0; c < CH; c++) begin
        e = exp_vec(c, cyc);
        g = {step_out[c], dir_out[c], busy[c], done[c], remaining[c*CNT_W +: CNT_W]};
        n_cmp++;
        if (g !== e) begin n_err++; $display("FAIL count_zero ch%0d edge %0d: got %h expected %h", c, cyc, g, e); end
      end
    end
  endtask

  task automatic test_abort();
    logic [CNT_W+3:0] e, g;
    longint s0;
    set_ch(2, 4, 10, 1'b1);
    start[2] = 1'b1;
    tick();
    s0 = cyc;
    for (int i = 0; i < 40; i++) begin
      if (cyc + 1 == s0 + 27) abort[2] = 1'b1;
      tick();
      if (cyc == s0 + 27) begin
        n_cmp++;
        if ({step_out[2], done[2], remaining[2*CNT_W +: CNT_W]} !== {1'b0, 1'b1, 31'd7}) begin
          n_err++; $display("FAIL abort_high step/done/rem: got %b/%b/%0d expected 0/1/7",
                            step_out[2], done[2], remaining[2*CNT_W +: CNT_W]);
        end
      end
      for (int c = 0; c < CH; c++) begin
        e = exp_vec(c, cyc);
        g = {step_out[c], dir_out[c], busy[c], done[c], remaining[c*CNT_W +: CNT_W]};
        n_cmp++;
        if (g !== e) begin n_err++; $display("FAIL abort ch%0d edge %0d: got %h expected %h", c, cyc, g, e); end
      end
    end
  endtask

  task automatic test_restart_ignored();
    logic [CNT_W+3:0] e, g;
    longint s0;
    set_ch(0, 2, 4, 1'b0);
    start[0] = 1'b1;
    tick();
    s0 = cyc;
    for (int i = 0; i < 34; i++) begin
      if (cyc + 1 == s0 + 10 || cyc + 1 == s0 + 27) begin
        set_ch(0, 7, 9, 1'b1);
        start[0] = 1'b1;
      end
      tick();
      for (int c = 0; c < CH; c++) begin
        e = exp_vec(c, cyc);
        g = {step_out[c], dir_out[c], busy[c], done[c], remaining[c*CNT_W +: CNT_W]};
        n_cmp++;
        if (g !== e) begin n_err++; $display("FAIL restart ch%0d edge %0d: got %h expected %h", c, cyc, g, e); end
      end
    end
    n_cmp++;
    if ({dir_out[0], busy[0]} !== 2'b00) begin
      n_err++; $display("FAIL restart_dir_busy: got %b expected 00", {dir_out[0], busy[0]});
    end
  endtask

  task automatic test_all_channels();
    logic [CNT_W+3:0] e, g;
    int     hps [CH];
    longint r1 [CH];
    longint r2 [CH];
    hps = '{1, 2, 3, 5};
    for (int c = 0; c < CH; c++) begin
      set_ch(c, hps[c], 3, c[0]);
      r1[c] = -1;
      r2[c] = -1;
    end
    start = '1;
    for (int i = 0; i < 50; i++) begin
      tick();
      for (int c = 0; c < CH; c++) begin
        if (step_out[c] && r1[c] < 0) r1[c] = cyc;
        else if (step_out[c] && r2[c] < 0 && cyc > r1[c] + hps[c]) r2[c] = cyc;
        e = exp_vec(c, cyc);
        g = {step_out[c], dir_out[c], busy[c], done[c], remaining[c*CNT_W +: CNT_W]};
        n_cmp++;
        if (g !== e) begin n_err++; $display("FAIL all_ch ch%0d edge %0d: got %h expected %h", c, cyc, g, e); end
      end
    end
    for (int c = 0; c < CH; c++) begin
      n_cmp++;
      if (r2[c] - r1[c] !== 64'(2 * hps[c])) begin
        n_err++; $display("FAIL all_ch_period ch%0d: got %0d expected %0d", c, r2[c] - r1[c], 2 * hps[c]);
      end
    end
    start = '1;
    abort = '1;
    for (int i = 0; i < 4; i++) begin
      tick();
      for (int c = 0; c < CH; c++) begin
        e = exp_vec(c, cyc);
        g = {step_out[c], dir_out[c], busy[c], done[c], remaining[c*CNT_W +: CNT_W]};
        n_cmp++;
        if (g !== e) begin n_err++; $display("FAIL start_abort ch%0d edge %0d: got %h expected %h", c, cyc, g, e); end
      end
    end
    n_cmp++;
    if ({busy, done, step_out} !== 12'h000) begin
      n_err++; $display("FAIL start_abort_idle: got %h expected 000", {busy, done, step_out});
    end
  endtask

  task automatic test_reset_midmove();
    logic [CNT_W+3:0] e, g;
    set_ch(0, 3, 5, 1'b1);
    start[0] = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    #2 reset = 1'b0;
    model_clear();
    #1;
    for (int c = 0; c < CH; c++) begin
      e = exp_vec(c, cyc);
      g = {step_out[c], dir_out[c], busy[c], done[c], remaining[c*CNT_W +: CNT_W]};
      n_cmp++;
      if (g !== e) begin n_err++; $display("FAIL reset_mid ch%0d: got %h expected %h", c, g, e); end
    end
    tick(); tick();
    reset = 1'b1;
    test_basic("after_reset");
  endtask

  task automatic test_random();
    logic [CNT_W+3:0] e, g;
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < CH; c++) begin
        set_ch(c, int'($urandom_range(0, 4)), int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)));
        start[c] = ($urandom_range(0, 3) == 0);
        abort[c] = ($urandom_range(0, 24) == 0);
      end
      tick();
      for (int c = 0; c < CH; c++) begin
        e = exp_vec(c, cyc);
        g = {step_out[c], dir_out[c], busy[c], done[c], remaining[c*CNT_W +: CNT_W]};
        n_cmp++;
        if (g !== e) begin n_err++; $display("FAIL random ch%0d edge %0d: got %h expected %h", c, cyc, g, e); end
      end
    end
  endtask

  initial begin
    start       = '0;
    abort       = '0;
    dir_in      = '0;
    half_period = '0;
    step_count  = '0;
    model_clear();
    test_reset();
    test_basic("basic");
    test_hp_zero();
    test_abort();
    test_restart_ignored();
    test_all_channels();
    test_reset_midmove();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
